matrix_mult_ctrl: RTL and testbench
===================================

# matrix_mult_ctrl

Sequencer that computes C = A × B over three matrix_10x10 storage instances. It issues row/column reads to A and B, multiplies and accumulates each dot product, and writes the result into C. It sits between the host, which loads A and B and later reads C, and the three matrix arrays. During a run it is the sole master of A/B read ports and of C's write port. One start request produces one full 10×10 product and a single done pulse.

## Interface
Parameters:
- DATA_WIDTH, 8, element width of A and B (unsigned)
- ACC_WIDTH, 2*DATA_WIDTH+4, accumulator and C element width (C instantiated with DATA_WIDTH=ACC_WIDTH)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request one multiply; sampled only in IDLE
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse after final C write
- aRead  out  1  en_ReadMat of A
- aRow, aCol  out  4 each  A address
- aData  in  DATA_WIDTH  readData of A
- bRead  out  1  en_ReadMat of B
- bRow, bCol  out  4 each  B address
- bData  in  DATA_WIDTH  readData of B
- cWrite  out  1  en_WriteMat of C
- cRow, cCol  out  4 each  C address
- cData  out  ACC_WIDTH  writeData of C

## Operation
- Matrix read contract: readData is registered. Data for an address presented with en_ReadMat at edge E is valid during the cycle after E. Write is committed at the edge where en_WriteMat is high.
- Counters: i (row), j (col), k (inner), each 0..9. An element index (i,j) steps j-first; j wraps 9→0 with i+1.
- FSM states: IDLE, READ, LAST, WRITE.
  - IDLE: all enables 0. When start=1, clear i/j/k and go to READ.
  - READ: aRead=bRead=1, aRow=i, aCol=k, bRow=k, bCol=j. If k<9, k+1 and stay. If k==9, go to LAST with k←0.
  - LAST: no reads. The final product (k=9) is accumulated. Go to WRITE.
  - WRITE: cWrite=1, cRow=i, cCol=j, cData=acc.
    - If (i,j)==(9,9), go to IDLE and pulse done.
    - Otherwise advance (i,j) and go to READ.
- Accumulate pipeline:
  - A registered flag vld is set one cycle after each READ cycle, with kd = the k that was issued.
  - When vld is high: acc ← (kd==0 ? 0 : acc) + aData*bData.
- Arithmetic: unsigned. The product is 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH. The sum wraps modulo 2^ACC_WIDTH; with defaults no overflow is possible (max 650250 < 2^20).
- Outside active cycles, addresses and cData are driven to 0.
- start while busy is ignored and has no latched effect. start in the done cycle is accepted, because the FSM is in IDLE then.

## Timing
- Reset (async assert): state IDLE, i=j=k=0, acc=0, vld=0. All outputs 0: busy, done, aRead, bRead, cWrite, all addresses, cData.
- Reset mid-run: outputs drop to 0 immediately and no done is produced. C may be partially written.
- Let start be accepted at edge E0, with cycle n meaning the cycle after edge E0+n-1.
- Per element: 12 cycles (10 READ, 1 LAST, 1 WRITE). Element m (0..99) occupies cycles 12m+1 … 12m+12, with its write in cycle 12m+12.
- Full run: busy is high in cycles 1–1200. done=1 in cycle 1201 only, with busy=0.
- Latency start→done: 1201 cycles.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1 → all outputs 0, no reads or writes. Release rst_n → first READ occurs on the cycle after start is sampled.
- Identity: A=I, B random → C==B for all 100 entries. done in cycle 1201, high exactly 1 cycle.
- Saturation: A=B=all 0xFF → every C entry = 650250 (0x9EC0A).
- Sequence check: cycles 1–10 read A[0][0..9] and B[0..9][0]. C[0][0] is written in cycle 12, C[0][1] in cycle 24, C[9][9] in cycle 1200. No enable is high in any LAST cycle.
- start pulse in cycle 500 and start held high through the done cycle:
  - The pulse in cycle 500 is ignored.
  - Holding start through the done cycle launches a second run whose first READ is cycle 1202.
  - Both runs produce correct C.
- Reset asserted in cycle 600, released, then start again → enables go 0 asynchronously and there is no done from the aborted run. The restarted run produces correct C and done at its cycle 1201.

Source files
------------

// File: rtl/matrix_mult_ctrl.sv
// rtl/matrix_mult_ctrl.sv - sequencer computing C = A x B over three 10x10 matrix stores
module matrix_mult_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  aRead,
  output logic [3:0]            aRow,
  output logic [3:0]            aCol,
  input  logic [DATA_WIDTH-1:0] aData,
  output logic                  bRead,
  output logic [3:0]            bRow,
  output logic [3:0]            bCol,
  input  logic [DATA_WIDTH-1:0] bData,
  output logic                  cWrite,
  output logic [3:0]            cRow,
  output logic [3:0]            cCol,
  output logic [ACC_WIDTH-1:0]  cData
);

  typedef enum logic [1:0] {IDLE, READ, LAST, WRITE} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              i, j, k;
  logic [3:0]              i_nxt, j_nxt, k_nxt;
  logic                    done_q, done_nxt;
  logic                    vld;
  logic [3:0]              kd;
  logic [ACC_WIDTH-1:0]    acc;
  logic [2*DATA_WIDTH-1:0] prod;

  // Full-width unsigned product of the two operands returned by the stores
  assign prod = {{DATA_WIDTH{1'b0}}, aData} * {{DATA_WIDTH{1'b0}}, bData};

  assign busy = (state != IDLE);
  assign done = done_q;

  // State, loop counters and the registered done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      i      <= i_nxt;
      j      <= j_nxt;
      k      <= k_nxt;
      done_q <= done_nxt;
    end
  end

  // Next-state, counter stepping and store port drive
  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    j_nxt     = j;
    k_nxt     = k;
    done_nxt  = 1'b0;
    aRead     = 1'b0;
    aRow      = '0;
    aCol      = '0;
    bRead     = 1'b0;
    bRow      = '0;
    bCol      = '0;
    cWrite    = 1'b0;
    cRow      = '0;
    cCol      = '0;
    cData     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          i_nxt     = '0;
          j_nxt     = '0;
          k_nxt     = '0;
          state_nxt = READ;
        end
      end
      READ: begin
        aRead = 1'b1;
        aRow  = i;
        aCol  = k;
        bRead = 1'b1;
        bRow  = k;
        bCol  = j;
        if (k == 4'd9) begin
          k_nxt     = '0;
          state_nxt = LAST;
        end else begin
          k_nxt = k + 4'd1;
        end
      end
      // Bubble cycle: the k=9 product lands in acc before it is written out
      LAST: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        cWrite = 1'b1;
        cRow   = i;
        cCol   = j;
        cData  = acc;
        if (i == 4'd9 && j == 4'd9) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          if (j == 4'd9) begin
            j_nxt = '0;
            i_nxt = i + 4'd1;
          end else begin
            j_nxt = j + 4'd1;
          end
          state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply-accumulate one cycle behind each read; kd==0 restarts the dot product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      kd  <= '0;
      acc <= '0;
    end else begin
      vld <= (state == READ);
      kd  <= k;
      if (vld) begin
        acc <= ((kd == 4'd0) ? '0 : acc)
             + {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, prod};
      end
    end
  end

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// tb/tb_matrix_mult_ctrl.sv - self-checking bench for matrix_mult_ctrl
module tb_matrix_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy, done;
  logic        aRead, bRead, cWrite;
  logic [3:0]  aRow, aCol, bRow, bCol, cRow, cCol;
  logic [7:0]  aData, bData;
  logic [19:0] cData;

  logic [7:0]  ma [10][10];
  logic [7:0]  mb [10][10];
  logic [19:0] mc [10][10];

  int tests;
  int fails;

  wire [48:0] obs = {busy, done, aRead, aRow, aCol, bRead, bRow, bCol,
                     cWrite, cRow, cCol, cData};

  matrix_mult_ctrl #(.DATA_WIDTH(8), .ACC_WIDTH(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .aRead(aRead), .aRow(aRow), .aCol(aCol), .aData(aData),
    .bRead(bRead), .bRow(bRow), .bCol(bCol), .bData(bData),
    .cWrite(cWrite), .cRow(cRow), .cCol(cCol), .cData(cData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix stores: registered read, write committed at the enabling edge
  always @(posedge clk) begin
    if (aRead) aData <= ma[aRow][aCol];
    if (bRead) bData <= mb[bRow][bCol];
    if (cWrite) mc[cRow][cCol] <= cData;
  end

  function automatic logic [19:0] ref_c(input int r, input int c);
    int sum;
    sum = 0;
    for (int x = 0; x < 10; x++) sum += int'(ma[r][x]) * int'(mb[x][c]);
    return 20'(sum);
  endfunction

  // Expected outputs in cycle n of a run: 100 elements of 12 cycles, then done
  function automatic logic [48:0] exp_vec(input int n);
    int m, p, r, c;
    logic b, d, rd, wr;
    logic [3:0] ar, ac, br, bc, cr, cc;
    logic [19:0] cd;
    b = 0; d = 0; rd = 0; wr = 0;
    ar = 0; ac = 0; br = 0; bc = 0; cr = 0; cc = 0; cd = 0;
    if (n >= 1 && n <= 1200) begin
      b = 1;
      m = (n - 1) / 12;
      p = (n - 1) % 12;
      r = m / 10;
      c = m % 10;
      if (p < 10) begin
        rd = 1; ar = 4'(r); ac = 4'(p); br = 4'(p); bc = 4'(c);
      end else if (p == 11) begin
        wr = 1; cr = 4'(r); cc = 4'(c); cd = ref_c(r, c);
      end
    end else if (n == 1201) begin
      d = 1;
    end
    return {b, d, rd, ar, ac, rd, br, bc, wr, cr, cc, cd};
  endfunction

  task automatic load_random();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        ma[r][c] = 8'($urandom);
        mb[r][c] = 8'($urandom);
        mc[r][c] = '0;
      end
  endtask

  task automatic clear_c();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) mc[r][c] = '0;
  endtask

  // One run checked cycle by cycle; optional stray start pulse, start held
  // into the done cycle, or reset asserted at a given cycle
  task automatic run_seq(input string name, input bit prestarted, input int pulse_at,
                         input bit hold_end, input int abort_at);
    int last;
    logic [48:0] e;
    if (!prestarted) begin
      @(negedge clk);
      start = 1'b1;
    end
    last = hold_end ? 1201 : 1202;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (abort_at != 0 && n == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== 49'd0) begin
          fails++;
          $display("FAIL %s async_reset cycle %0d: got %h expected 0", name, n, obs);
        end
        for (int q = 0; q < 2; q++) begin
          @(negedge clk);
          tests++;
          if (obs !== 49'd0) begin
            fails++;
            $display("FAIL %s held_reset: got %h expected 0", name, obs);
          end
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== 49'd0) begin
          fails++;
          $display("FAIL %s after_reset: got %h expected 0 (no done)", name, obs);
        end
        return;
      end
      e = exp_vec(n);
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, n, obs, e);
      end
      start = (n == pulse_at) || (hold_end && n >= 1200);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    for (int q = 0; q < 3; q++) begin
      @(negedge clk);
      tests++;
      if (obs !== 49'd0) begin
        fails++;
        $display("FAIL reset cycle %0d: got %h expected 0", q, obs);
      end
    end
    load_random();
    rst_n = 1'b1;
    run_seq("reset_release", 1'b1, 0, 1'b0, 0);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        tests++;
        if (mc[r][c] !== ref_c(r, c)) begin
          fails++;
          $display("FAIL reset_release C[%0d][%0d]: got %0d expected %0d", r, c, mc[r][c], ref_c(r, c));
        end
      end
  endtask

  task automatic test_identity();
    load_random();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) ma[r][c] = (r == c) ? 8'd1 : 8'd0;
    run_seq("identity", 1'b0, 0, 1'b0, 0);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        tests++;
        if (mc[r][c] !== {12'd0, mb[r][c]}) begin
          fails++;
          $display("FAIL identity C[%0d][%0d]: got %0d expected %0d", r, c, mc[r][c], mb[r][c]);
        end
      end
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        ma[r][c] = 8'hFF;
        mb[r][c] = 8'hFF;
        mc[r][c] = '0;
      end
    run_seq("saturation", 1'b0, 0, 1'b0, 0);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        tests++;
        if (mc[r][c] !== 20'd650250) begin
          fails++;
          $display("FAIL saturation C[%0d][%0d]: got %0d expected 650250", r, c, mc[r][c]);
        end
      end
  endtask

  task automatic test_back_to_back();
    load_random();
    run_seq("b2b_first", 1'b0, 500, 1'b1, 0);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        tests++;
        if (mc[r][c] !== ref_c(r, c)) begin
          fails++;
          $display("FAIL b2b_first C[%0d][%0d]: got %0d expected %0d", r, c, mc[r][c], ref_c(r, c));
        end
      end
    clear_c();
    run_seq("b2b_second", 1'b1, 0, 1'b0, 0);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        tests++;
        if (mc[r][c] !== ref_c(r, c)) begin
          fails++;
          $display("FAIL b2b_second C[%0d][%0d]: got %0d expected %0d", r, c, mc[r][c], ref_c(r, c));
        end
      end
  endtask

  task automatic test_abort();
    load_random();
    run_seq("abort", 1'b0, 0, 1'b0, 600);
    clear_c();
    run_seq("restart", 1'b0, 0, 1'b0, 0);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++) begin
        tests++;
        if (mc[r][c] !== ref_c(r, c)) begin
          fails++;
          $display("FAIL restart C[%0d][%0d]: got %0d expected %0d", r, c, mc[r][c], ref_c(r, c));
        end
      end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_identity();
    test_saturation();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
